// File: rtl/imul_pkg.sv
// imul_pkg: shared definitions for the iterative 32-bit multiplier.
// Contents: FSM state encoding, operand width, last iteration index.
// Optional feature macro used by the multiplier: IMUL_EARLY_EXIT_EN.
package imul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } imul_state_e;

    localparam int unsigned IMUL_NBITS    = 32;
    localparam logic [4:0]  IMUL_CNT_LAST = 5'd31;

endpackage

// File: rtl/imul_iterative_32b_adder.sv
// Adder_32b_GL: gate-level 32-bit ripple-carry adder built from
// explicit full-adder equations. There is no carry-in or carry-out.
// The multiplier keeps only the low 32 bits of each sum.
// Ports:
//   in0 [31:0] - addend
//   in1 [31:0] - addend
//   sum [31:0] - (in0 + in1) mod 2^32
module Adder_32b_GL
    import imul_pkg::*;
(
    input  logic [IMUL_NBITS-1:0] in0,
    input  logic [IMUL_NBITS-1:0] in1,
    output logic [IMUL_NBITS-1:0] sum
);

    // carry[i] is the carry into bit i. The carry out of bit 31 is never formed.
    logic [IMUL_NBITS-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < IMUL_NBITS; i++) begin : g_fa
        assign sum[i] = in0[i] ^ in1[i] ^ carry[i];
        if (i < IMUL_NBITS - 1) begin : g_carry
            assign carry[i+1] = (in0[i] & in1[i]) | (carry[i] & (in0[i] ^ in1[i]));
        end
    end

endmodule

// File: rtl/imul_iterative_32b.sv
// imul_iterative_32b: iterative shift-add multiplier.
// It returns (in0*in1) mod 2^32, which is TinyRV1 mul.
// Every accumulation goes through Adder_32b_GL.
// Ports:
//   clk, rst_n             - clock; asynchronous active-low reset
//   istream_val/rdy        - operand handshake (rdy decoded from state)
//   in0, in1 [31:0]        - multiplicand, multiplier
//   ostream_val/rdy        - result handshake (val decoded from state)
//   result [31:0]          - product low word, held stable in DONE
// Optional macro IMUL_EARLY_EXIT_EN: CALC ends as soon as the
// remaining multiplier is zero. This does not change the result.
module imul_iterative_32b
    import imul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  istream_val,
    output logic                  istream_rdy,
    input  logic [IMUL_NBITS-1:0] in0,
    input  logic [IMUL_NBITS-1:0] in1,
    output logic                  ostream_val,
    input  logic                  ostream_rdy,
    output logic [IMUL_NBITS-1:0] result
);

    imul_state_e           state_q, state_d;
    logic [IMUL_NBITS-1:0] a_q, b_q, acc_q;
    logic [4:0]            cnt_q;
    logic [IMUL_NBITS-1:0] sum;
    logic                  load;
    logic                  step;

    Adder_32b_GL u_adder (
        .in0 (acc_q),
        .in1 (a_q),
        .sum (sum)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef IMUL_EARLY_EXIT_EN
                // A zero multiplier contributes nothing further.
                // Leave CALC now and keep all registers frozen.
                if (b_q == '0) begin
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == IMUL_CNT_LAST) state_d = DONE;
                end
`else
                step = 1'b1;
                if (cnt_q == IMUL_CNT_LAST) state_d = DONE;
`endif
            end
            DONE: begin
                if (ostream_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q   <= in0;
                b_q   <= in1;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (step) begin
                if (b_q[0]) acc_q <= sum;
                a_q   <= a_q << 1;
                b_q   <= b_q >> 1;
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign istream_rdy = (state_q == IDLE);
    assign ostream_val = (state_q == DONE);
    assign result      = acc_q;

endmodule
